uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
Sequencing stage between rx_uart and tx_uart inside top. Collects three received bytes in order: operand A, operand B, opcode. Presents them as registered operands to the combinational ALU, latches the ALU result, then hands it to tx_uart with a one-cycle start pulse. Also handles inter-byte timeout resync, invalid-opcode rejection and overrun flagging.

Parameters:
NB_DATA, 8, data/operand/result width
NB_OP, 6, opcode width presented to ALU
NB_STATE, 3, FSM state register width
TIMEOUT_CYCLES, 2500000, max i_clock cycles between bytes of one frame (50 ms @ 50 MHz)
NB_TIMEOUT, 22, timeout counter width (must hold TIMEOUT_CYCLES-1)

Ports:
i_clock  in  1  system clock
i_reset  in  1  reset, asynchronous, active-high
i_rx_data  in  NB_DATA  byte from rx_uart, valid when i_rx_done_tick=1
i_rx_done_tick  in  1  one-cycle pulse, byte received
i_alu_result  in  NB_DATA  combinational ALU output driven from o_data_a/o_data_b/o_opcode
i_tx_done_tick  in  1  one-cycle pulse from tx_uart, stop bit finished
o_data_a  out  NB_DATA  registered operand A
o_data_b  out  NB_DATA  registered operand B
o_opcode  out  NB_OP  registered opcode (i_rx_data[NB_OP-1:0])
o_tx_data  out  NB_DATA  latched result to tx_uart
o_tx_start  out  1  one-cycle pulse, start transmission
o_busy  out  1  high in every state except WAIT_A
o_err  out  1  one-cycle pulse, invalid opcode
o_timeout  out  1  one-cycle pulse, frame aborted by inter-byte timeout
o_overrun  out  1  one-cycle pulse, byte received while EXEC/SEND/WAIT_TX

Behaviour:
- Reset (async, i_reset=1): state WAIT_A; all outputs 0; timeout counter 0. Reset mid-frame discards partial frame.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done_tick latch o_data_a <= i_rx_data -> WAIT_B. No timeout in WAIT_A.
- WAIT_B: on tick latch o_data_b -> WAIT_OP.
- WAIT_OP: on tick, if i_rx_data[7:6]==0 and low 6 bits in valid set: latch o_opcode -> EXEC. Otherwise o_err=1 for one cycle, o_opcode unchanged -> WAIT_A.
- Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- EXEC: single cycle; o_tx_data <= i_alu_result (operands already stable one cycle) -> SEND.
- SEND: o_tx_start=1 for exactly this cycle -> WAIT_TX.
- WAIT_TX: hold until i_tx_done_tick -> WAIT_A. No timeout here.
- Latency: opcode tick at cycle n -> EXEC n+1 -> o_tx_start high at n+2.
- Timeout: counter cleared on entering WAIT_B/WAIT_OP; increments each cycle in those states. When it reaches TIMEOUT_CYCLES-1 without a tick: o_timeout pulse -> WAIT_A, o_data_a/o_data_b keep their values. A tick in that same cycle wins over timeout.
- i_rx_done_tick in EXEC/SEND/WAIT_TX: byte dropped, o_overrun pulse, no register change.
- i_tx_done_tick outside WAIT_TX: ignored.
- Simultaneous i_rx_done_tick and i_tx_done_tick in WAIT_TX: go WAIT_A, flag overrun, byte dropped (not taken as A).
- Width: result is i_alu_result as-is, NB_DATA bits, no extension; wrap-around belongs to ALU.

Decomposition:
- Shared package/header alu_defs: opcode localparams (ADD..SRL), NB_OP, NB_DATA, state encodings.
- One sub-module: uart_gap_timer (NB_TIMEOUT counter, clear/enable inputs, expire pulse at TIMEOUT_CYCLES-1).

Test Plan:
- A=85, B=1, op=32 (ADD), ALU stub = A+B -> o_tx_data=86, o_tx_start single pulse 2 cycles after opcode tick, o_busy low after tx_done.
- A=5, B=7, op=34 (SUB) -> o_tx_data=0xFE (wrap), one o_tx_start.
- A=3, B=4, op=0x3F -> o_err pulse, no o_tx_start, state WAIT_A, o_busy=0.
- TIMEOUT_CYCLES=100; send A, idle 100 cycles -> o_timeout at cycle 99 after WAIT_B entry; then frame 10,20,ADD -> o_tx_data=30.
- Rx tick during WAIT_TX -> o_overrun pulse, o_tx_data unchanged, next frame decoded correctly.
- Reset asserted after B received -> outputs 0 immediately (async), next frame 1,2,ADD -> o_tx_data=3.

Source files
------------

// File: rtl/alu_defs.sv
// alu_defs: shared widths, opcodes, FSM encodings and opcode validity check for the UART/ALU sequencer
package alu_defs;
  localparam int NB_DATA  = 8;
  localparam int NB_OP    = 6;
  localparam int NB_STATE = 3;
  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_STATE-1:0] WAIT_A  = 3'd0;
  localparam logic [NB_STATE-1:0] WAIT_B  = 3'd1;
  localparam logic [NB_STATE-1:0] WAIT_OP = 3'd2;
  localparam logic [NB_STATE-1:0] EXEC    = 3'd3;
  localparam logic [NB_STATE-1:0] SEND    = 3'd4;
  localparam logic [NB_STATE-1:0] WAIT_TX = 3'd5;
  function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: inter-byte gap counter; clk/rst (async high), clr zeroes it, en counts, expire flags the last allowed cycle
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int NB_TIMEOUT     = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [NB_TIMEOUT-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = en && cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B, opcode from rx, drives registered ALU operands, latches result and starts tx; flags err/timeout/overrun pulses
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_STATE       = 3,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int NB_TIMEOUT     = 22
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_timeout,
  output logic               o_overrun
);
  import alu_defs::*;
  logic [NB_STATE-1:0] state, nxt;
  logic counting, expire, op_ok, draining;
  assign counting = state == WAIT_B || state == WAIT_OP;
  assign draining = state == EXEC || state == SEND || state == WAIT_TX;
  assign op_ok    = i_rx_data[NB_DATA-1:NB_OP] == '0 && is_valid_op(i_rx_data[NB_OP-1:0]);
  // a received byte also clears the gap counter so the next state starts from zero
  uart_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .NB_TIMEOUT(NB_TIMEOUT)) u_gap_timer (
    .clk(i_clock),
    .rst(i_reset),
    .clr(!counting || i_rx_done_tick),
    .en(counting),
    .expire(expire)
  );
  assign o_busy     = state != WAIT_A;
  assign o_tx_start = state == SEND;
  assign o_err      = state == WAIT_OP && i_rx_done_tick && !op_ok;
  assign o_timeout  = expire && !i_rx_done_tick;
  assign o_overrun  = draining && i_rx_done_tick;
  always_comb begin
    nxt = state;
    case (state)
      WAIT_A:  nxt = i_rx_done_tick ? WAIT_B : WAIT_A;
      WAIT_B:  nxt = i_rx_done_tick ? WAIT_OP : expire ? WAIT_A : WAIT_B;
      WAIT_OP: nxt = i_rx_done_tick ? (op_ok ? EXEC : WAIT_A) : expire ? WAIT_A : WAIT_OP;
      EXEC:    nxt = SEND;
      SEND:    nxt = WAIT_TX;
      WAIT_TX: nxt = i_tx_done_tick ? WAIT_A : WAIT_TX;
      default: nxt = WAIT_A;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state     <= WAIT_A;
      o_data_a  <= '0;
      o_data_b  <= '0;
      o_opcode  <= '0;
      o_tx_data <= '0;
    end else begin
      state <= nxt;
      if (state == WAIT_A && i_rx_done_tick) o_data_a <= i_rx_data;
      if (state == WAIT_B && i_rx_done_tick) o_data_b <= i_rx_data;
      if (state == WAIT_OP && i_rx_done_tick && op_ok) o_opcode <= i_rx_data[NB_OP-1:0];
      if (state == EXEC) o_tx_data <= i_alu_result;
    end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: randomized and directed scenario checks of the UART/ALU sequencer against a behavioural model
module tb_uart_alu_interface;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, alu_result, data_a, data_b, tx_data;
  logic [5:0] opcode;
  logic rx_tick = 0, tx_done = 0, tx_start, busy, err, tmo, ovr;
  int checks = 0, fails = 0;
  int n_start = 0, n_err = 0, n_tmo = 0, n_ovr = 0;
  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_ref(input logic [7:0] a, b, input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: r = $signed(a) >>> b;
      6'h02: r = a >> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction
  function automatic bit is_op(input logic [5:0] o);
    foreach (ops[i]) if (ops[i] == o) return 1;
    return 0;
  endfunction
  assign alu_result = alu_ref(data_a, data_b, opcode);
  uart_alu_interface #(.TIMEOUT_CYCLES(100)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done_tick(rx_tick),
    .i_alu_result(alu_result), .i_tx_done_tick(tx_done), .o_data_a(data_a), .o_data_b(data_b),
    .o_opcode(opcode), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
    .o_err(err), .o_timeout(tmo), .o_overrun(ovr)
  );
  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (err) n_err++;
    if (tmo) n_tmo++;
    if (ovr) n_ovr++;
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_data = b; rx_tick = 1;
    @(posedge clk); #1 rx_tick = 0;
  endtask
  task automatic tx_finish();
    repeat (2) @(posedge clk);
    #1 tx_done = 1;
    @(posedge clk); #1 tx_done = 0;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({data_a, data_b, opcode, tx_data, tx_start, busy, err, tmo, ovr} !== '0) begin
      fails++; $display("FAIL reset_state: got a=%h b=%h op=%h tx=%h flags=%b%b%b%b%b, required all zero",
        data_a, data_b, opcode, tx_data, tx_start, busy, err, tmo, ovr);
    end
    @(posedge clk); #1 rst = 0;
  endtask
  task automatic test_frame(input logic [7:0] a, b, input logic [5:0] op, input logic [7:0] exp, input string name);
    int s0 = n_start;
    send_byte(a); send_byte(b); send_byte({2'b00, op});
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL %s exec_cycle: tx_start=%b busy=%b, required 0/1", name, tx_start, busy);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin
      fails++; $display("FAIL %s start_latency: tx_start=%b two cycles after opcode, required 1", name, tx_start);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_data !== exp || data_a !== a || data_b !== b || opcode !== op) begin
      fails++; $display("FAIL %s result: tx=%h a=%h b=%h op=%h, required tx=%h a=%h b=%h op=%h",
        name, tx_data, data_a, data_b, opcode, exp, a, b, op);
    end
    tx_finish();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_start - s0 !== 1) begin
      fails++; $display("FAIL %s after_tx: busy=%b starts=%0d, required busy=0 starts=1", name, busy, n_start - s0);
    end
  endtask
  task automatic test_directed();
    test_frame(8'd85, 8'd1, 6'd32, 8'd86, "add_85_1");
    test_frame(8'd5, 8'd7, 6'd34, 8'hFE, "sub_wrap");
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a, b;
      logic [5:0] op;
      a = 8'($urandom); b = 8'($urandom); op = ops[$urandom_range(0, 7)];
      if (op == 6'h03 || op == 6'h02) b = 8'($urandom_range(0, 9));
      test_frame(a, b, op, alu_ref(a, b, op), "random");
    end
  endtask
  task automatic test_invalid();
    logic [5:0] op_before;
    logic [7:0] bad [3];
    logic [5:0] v;
    do v = 6'($urandom); while (is_op(v));
    bad[0] = 8'h3F; bad[1] = {2'b01, 6'h20}; bad[2] = {2'b00, v};
    foreach (bad[i]) begin
      int se = n_err, ss = n_start;
      op_before = opcode;
      send_byte(8'd3); send_byte(8'd4); send_byte(bad[i]);
      repeat (4) @(negedge clk);
      checks++;
      if (n_err - se !== 1 || n_start !== ss || busy !== 1'b0 || opcode !== op_before) begin
        fails++; $display("FAIL invalid_op %h: errs=%0d starts=%0d busy=%b op=%h, required errs=1 starts=0 busy=0 op=%h",
          bad[i], n_err - se, n_start - ss, busy, opcode, op_before);
      end
    end
  endtask
  task automatic test_timeout();
    int t = -1, st = n_tmo;
    send_byte(8'h44);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tmo) begin t = i; break; end
    end
    checks++;
    if (t != 99) begin
      fails++; $display("FAIL timeout_b_cycle: timeout seen at cycle %0d, required 99", t);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || data_a !== 8'h44 || n_tmo - st !== 1) begin
      fails++; $display("FAIL timeout_b_state: busy=%b a=%h pulses=%0d, required busy=0 a=44 pulses=1", busy, data_a, n_tmo - st);
    end
    st = n_tmo;
    send_byte(8'h55);
    repeat (98) @(posedge clk);
    send_byte(8'h66);
    checks++;
    if (n_tmo !== st || busy !== 1'b1 || data_b !== 8'h66) begin
      fails++; $display("FAIL tick_wins: pulses=%0d busy=%b b=%h, required pulses=0 busy=1 b=66", n_tmo - st, busy, data_b);
    end
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tmo) begin t = i; break; end
    end
    checks++;
    if (t != 99) begin
      fails++; $display("FAIL timeout_op_cycle: timeout seen at cycle %0d, required 99", t);
    end
    @(posedge clk); #1;
    test_frame(8'd10, 8'd20, 6'h20, 8'd30, "after_timeout");
  endtask
  task automatic test_overrun();
    int so = n_ovr, ss = n_start;
    send_byte(8'h21); send_byte(8'h12); send_byte(8'h26);
    send_byte(8'h5A);
    send_byte(8'h6B);
    checks++;
    if (n_ovr - so !== 2 || tx_data !== 8'h33 || data_a !== 8'h21 || data_b !== 8'h12 || busy !== 1'b1 || n_start - ss !== 1) begin
      fails++; $display("FAIL overrun_drop: pulses=%0d tx=%h a=%h b=%h busy=%b starts=%0d, required 2/33/21/12/1/1",
        n_ovr - so, tx_data, data_a, data_b, busy, n_start - ss);
    end
    @(posedge clk); #1 rx_data = 8'h77; rx_tick = 1; tx_done = 1;
    @(posedge clk); #1 rx_tick = 0; tx_done = 0;
    @(posedge clk); #1;
    checks++;
    if (n_ovr - so !== 3 || busy !== 1'b0 || data_a !== 8'h21) begin
      fails++; $display("FAIL overrun_with_tx_done: pulses=%0d busy=%b a=%h, required 3/0/21", n_ovr - so, busy, data_a);
    end
    test_frame(8'd200, 8'd100, 6'h20, 8'd44, "after_overrun");
  endtask
  task automatic test_tx_done_ignored();
    tx_finish();
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL txdone_idle: busy=%b, required 0", busy);
    end
    send_byte(8'hF0);
    tx_finish();
    checks++;
    if (busy !== 1'b1 || data_a !== 8'hF0) begin
      fails++; $display("FAIL txdone_wait_b: busy=%b a=%h, required busy=1 a=f0", busy, data_a);
    end
    send_byte(8'h0F); send_byte(8'h25);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tx_data !== 8'hFF || busy !== 1'b1) begin
      fails++; $display("FAIL txdone_frame: tx=%h busy=%b, required ff/1", tx_data, busy);
    end
    tx_finish();
  endtask
  task automatic test_reset_midframe();
    send_byte(8'h11); send_byte(8'h22);
    #3 rst = 1;
    #1;
    checks++;
    if ({data_a, data_b, opcode, tx_data, tx_start, busy, err, tmo, ovr} !== '0) begin
      fails++; $display("FAIL async_reset: a=%h b=%h op=%h tx=%h busy=%b, required all zero", data_a, data_b, opcode, tx_data, busy);
    end
    @(posedge clk); #1 rst = 0;
    test_frame(8'd1, 8'd2, 6'h20, 8'd3, "after_reset");
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_invalid();
    test_timeout();
    test_overrun();
    test_tx_done_ignored();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
